// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver for the BCD adder result (00..19).
// Scans units/tens with optional blank gaps; flags invalid units digits.
module bcd_seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] sum_i,
    input  logic       cout_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [1:0] an_o,
    output logic       err_o,
    output logic       loaded_o
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] T_SHOW = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] T_GAP  = (BLANK_CYC == 0) ? '0 : CW'(BLANK_CYC - 1);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_U,
        GAP_T,
        SHOW_T,
        GAP_U
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    units_q;
    logic          tens_q;
    logic          err_q;
    logic          loaded_q;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b0000110;
        endcase
        return s;
    endfunction

    // Capture and scan advance are independent: a load never moves the scan phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            units_q  <= '0;
            tens_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            if (load_i) begin
                units_q  <= sum_i;
                tens_q   <= cout_i;
                err_q    <= (sum_i > 4'd9);
                loaded_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (load_i) begin
                        state <= SHOW_U;
                        cnt   <= '0;
                    end
                end
                SHOW_U: begin
                    if (cnt == T_SHOW) begin
                        state <= (BLANK_CYC == 0) ? SHOW_T : GAP_T;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP_T: begin
                    if (cnt == T_GAP) begin
                        state <= SHOW_T;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW_T: begin
                    if (cnt == T_SHOW) begin
                        state <= (BLANK_CYC == 0) ? SHOW_U : GAP_U;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP_U: begin
                    if (cnt == T_GAP) begin
                        state <= SHOW_U;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        an_o  = 2'b11;
        seg_o = BLANK;
        unique case (state)
            SHOW_U: begin
                an_o  = 2'b10;
                seg_o = enc(units_q);
            end
            SHOW_T: begin
                an_o = 2'b01;
                if (tens_q) begin
                    seg_o = enc(4'd1);
                end else if (!LZ_BLANK) begin
                    seg_o = enc(4'd0);
                end
            end
            default: begin
                an_o  = 2'b11;
                seg_o = BLANK;
            end
        endcase
    end

    assign dp_o     = 1'b1;
    assign err_o    = err_q;
    assign loaded_o = loaded_q;

endmodule
